testpattern_axis_gen: RTL and testbench
=======================================

# testpattern_axis_gen

Parametrised test-image generator for the video write path. It emits a configurable-resolution frame sequence on an AXI4-Stream master port with SOF on TUSER and EOL on TLAST, so it can feed the S2MM VDMA directly. It is the successor to the fixed 640x480 ramp writer: it adds runtime resolution, four pattern modes, multi-frame and continuous runs, and full backpressure handling. Control and status come from the register block.

## Interface
- DATA_WIDTH, 24: TDATA width; must be a multiple of 3; component width C = DATA_WIDTH/3.
- CNT_WIDTH, 12: width of the H/V size inputs and the line and pixel counters.
- CHK_LOG2, 5: checkerboard square edge is 2^CHK_LOG2 pixels.
- CLK  in  1  sole clock.
- RSTN  in  1  asynchronous, active-low reset.
- TESTON  in  1  run enable, level; may be asynchronous to CLK.
- MODE  in  2  pattern select: 0 ramp, 1 colour bars, 2 checkerboard, 3 solid.
- H_SIZE, V_SIZE  in  CNT_WIDTH each  active pixels per line, lines per frame.
- FRAMES  in  16  frame count; 0 means continuous.
- SOLID_COLOR  in  DATA_WIDTH  pixel value used in mode 3.
- M_AXIS_TDATA  out  DATA_WIDTH  pixel.
- M_AXIS_TVALID  out  1; M_AXIS_TREADY  in  1.
- M_AXIS_TLAST  out  1  last pixel of line.
- M_AXIS_TUSER  out  1  first pixel of frame.
- TESTEND  out  1  requested frame count completed.
- TEST_PIXELCNT  out  32  beats accepted since start, wrapping.
- TEST_FRAMECNT  out  16  frames completed since start, wrapping.

## Operation
- TESTON passes through a 2-flop synchroniser. The start pulse is the rising edge of the synchronised signal.
- States:
  - IDLE to RUN on the start pulse when H_SIZE!=0 and V_SIZE!=0. Otherwise stay in IDLE.
  - RUN to DONE on acceptance of the last pixel of frame FRAMES (FRAMES!=0).
  - RUN to IDLE on acceptance of the last pixel of any frame while synchronised TESTON is low.
  - DONE to IDLE when synchronised TESTON is low.
  - DONE to RUN on a start pulse.
- A start pulse while in RUN is ignored.
- On entering RUN: MODE, H_SIZE, V_SIZE, FRAMES and SOLID_COLOR are latched, and all counters and TEST_* status are cleared. Input changes during RUN have no effect.
- TESTON falling mid-frame never truncates the frame. The frame is completed, then the block returns to IDLE.
- Counters advance only on a handshake (TVALID & TREADY):
  - hcnt wraps at H_SIZE-1 and increments vcnt.
  - vcnt wraps at V_SIZE-1 and increments the frame count.
- Patterns, with components packed {c2,c1,c0}:
  - Ramp: each component is (frame pixel index + 1) mod 2^C. The index restarts at 0 every frame.
  - Bars: bar width bw = max(H_SIZE>>3, 1), latched at start. The bar index advances every bw pixels, saturates at 7 and resets each line. Colours in order: white, yellow, cyan, green, magenta, red, blue, black (components all-ones or zero).
  - Checker: white when hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2] = 0, else black.
  - Solid: latched SOLID_COLOR.
- TUSER is high when hcnt==0 and vcnt==0. TLAST is high when hcnt==H_SIZE-1.
- For H_SIZE=1, every beat carries TLAST.
- FRAMES=0: runs until TESTON falls. TESTEND never asserts. TEST_FRAMECNT wraps at 2^16.

## Timing
- Reset values:
  - State IDLE.
  - TVALID, TLAST, TUSER, TESTEND = 0.
  - TDATA = 0.
  - TEST_PIXELCNT, TEST_FRAMECNT = 0.
- TESTON is first sampled high at edge E1. TVALID is high after edge E3.
- The first beat carries TUSER=1 and TLAST=(H_SIZE==1).
- All AXIS outputs are registered.
- While TVALID=1 and TREADY=0, TDATA, TLAST and TUSER are held stable.
- TVALID never drops without a handshake.
- Throughput is one beat per cycle under continuous TREADY. There are no gaps between lines or frames.
- TESTEND rises in the cycle after the final handshake, together with TVALID falling. It stays high until the next start pulse or reset.
- Status counters update in the cycle after the handshake.
- RSTN asserted mid-frame drops TVALID immediately (asynchronously). Recovery requires a new TESTON rising edge.

## Configuration
- TESTPAT_CHECKSUM_EN defined:
  - Adds output TEST_CHECKSUM[31:0], the 32-bit wrapping sum of all accepted TDATA in the most recent completed frame.
  - It updates in the cycle after that frame's last handshake.
  - Reset value 0; cleared on start.
- TESTPAT_CHECKSUM_EN undefined: the port and the adder are absent. All other behaviour is identical.

## Structure
- The shared package testpattern_pkg holds:
  - the mode enum;
  - the state enum (IDLE/RUN/DONE);
  - the 8 bar colours as a function of C.
- Sub-module testpattern_sync_edge is the 2-flop synchroniser plus rising-edge detector, reset to 0 by RSTN.
- The pattern mux is combinational from latched config and counters, then registered into TDATA.

## Test plan
- Ramp, 4x2, FRAMES=1, TREADY=1:
  - 8 beats 0x010101 to 0x080808;
  - TUSER on beat 1 only, TLAST on beats 4 and 8;
  - TESTEND=1 and TEST_PIXELCNT=8 afterwards.
- Same ramp with TREADY toggling 1,0,0,1:
  - TDATA/TLAST stable during stalls;
  - identical 8-beat sequence;
  - TVALID held throughout.
- Bars, 16x1:
  - beats are white,white,yellow,yellow,...,black,black (pairs);
  - 0xFFFFFF first, 0x000000 last, TLAST on beat 16.
- Checker with CHK_LOG2=1, 4x4: lines 0-1 read W,W,B,B and lines 2-3 read B,B,W,W.
- FRAMES=0, 2x2 solid 0x123456, TESTON dropped after beat 5:
  - the frame completes at beat 8, then IDLE;
  - TEST_FRAMECNT=2, TESTEND=0.
- RSTN pulsed low mid-frame:
  - TVALID=0 immediately and all status is zero;
  - no output until a new TESTON rise, which restarts at TUSER with the first pixel.

Source files
------------

// File: rtl/testpattern_pkg.sv
// Shared types and helpers for the test-pattern AXI4-Stream generator.
package testpattern_pkg;

  typedef enum logic [1:0] {
    ModeRamp    = 2'd0,
    ModeBars    = 2'd1,
    ModeChecker = 2'd2,
    ModeSolid   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned NumBars = 8;

  // Per-component on/off mask {c2,c1,c0}; the caller replicates each bit to C bits.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] on;
    case (idx)
      3'd0:    on = 3'b111; // white
      3'd1:    on = 3'b110; // yellow
      3'd2:    on = 3'b011; // cyan
      3'd3:    on = 3'b010; // green
      3'd4:    on = 3'b101; // magenta
      3'd5:    on = 3'b100; // red
      3'd6:    on = 3'b001; // blue
      default: on = 3'b000; // black
    endcase
    return on;
  endfunction

endpackage

// File: rtl/testpattern_axis_gen_if.sv
// AXI4-Stream video bus: TUSER marks start of frame, TLAST marks end of line.
interface testpattern_axis_gen_if #(
  parameter int unsigned DataWidth = 24
) ();
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic                 tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/testpattern_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a rising-edge pulse.
module testpattern_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/testpattern_axis_gen.sv
// Test-image generator (ramp/bars/checker/solid) on an AXI4-Stream master.
// Define TESTPAT_CHECKSUM_EN to add the per-frame TDATA checksum output.
module testpattern_axis_gen
  import testpattern_pkg::*;
#(
  parameter int unsigned DataWidth = 24,
  parameter int unsigned CntWidth  = 12,
  parameter int unsigned ChkLog2   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 teston_i,
  input  logic [1:0]           mode_i,
  input  logic [CntWidth-1:0]  h_size_i,
  input  logic [CntWidth-1:0]  v_size_i,
  input  logic [15:0]          frames_i,
  input  logic [DataWidth-1:0] solid_color_i,
  output logic                 testend_o,
  output logic [31:0]          test_pixelcnt_o,
  output logic [15:0]          test_framecnt_o,
`ifdef TESTPAT_CHECKSUM_EN
  output logic [31:0]          test_checksum_o,
`endif
  testpattern_axis_gen_if.master m_axis
);

  localparam int unsigned CompWidth = DataWidth / 3;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic teston_lvl, start;

  testpattern_sync_edge u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (teston_i),
    .level_o (teston_lvl),
    .rise_o  (start)
  );

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [CntWidth-1:0]   hsize_q, hsize_d, vsize_q, vsize_d, bw_q, bw_d;
  logic [15:0]           frames_q, frames_d;
  logic [DataWidth-1:0]  solid_q, solid_d;
  logic [CntWidth-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d, bar_cnt_q, bar_cnt_d;
  logic [CompWidth-1:0]  ramp_q, ramp_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [DataWidth-1:0]  tdata_q, tdata_d, pix_d;
  logic                  testend_q, testend_d;
  logic [31:0]           pixcnt_q, pixcnt_d;
  logic [15:0]           framecnt_q, framecnt_d;

  logic hs, h_last, v_last, frame_end, final_frame, load, present;
  logic [CntWidth-1:0] bw_in;
  logic [2:0] bar_on;

  assign hs          = tvalid_q & m_axis.tready;
  assign h_last      = (hcnt_q == hsize_q - CntOne);
  assign v_last      = (vcnt_q == vsize_q - CntOne);
  assign frame_end   = hs & h_last & v_last;
  assign final_frame = (frames_q != 16'd0) && (framecnt_q + 16'd1 == frames_q);
  // A start pulse in RUN is ignored; zero-sized frames never start.
  assign load        = start & (h_size_i != '0) & (v_size_i != '0) & (state_q != StRun);
  assign bw_in       = ((h_size_i >> 3) == '0) ? CntOne : (h_size_i >> 3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (load) state_d = StRun;
      StRun: begin
        if (frame_end) begin
          if (final_frame)      state_d = StDone;
          else if (!teston_lvl) state_d = StIdle;
        end
      end
      StDone: begin
        if (load)             state_d = StRun;
        else if (!teston_lvl) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    hsize_d    = hsize_q;
    vsize_d    = vsize_q;
    bw_d       = bw_q;
    frames_d   = frames_q;
    solid_d    = solid_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    ramp_d     = ramp_q;
    bar_cnt_d  = bar_cnt_q;
    bar_idx_d  = bar_idx_q;
    tvalid_d   = tvalid_q;
    testend_d  = testend_q;
    pixcnt_d   = pixcnt_q;
    framecnt_d = framecnt_q;
    if (load) begin
      mode_d     = mode_e'(mode_i);
      hsize_d    = h_size_i;
      vsize_d    = v_size_i;
      bw_d       = bw_in;
      frames_d   = frames_i;
      solid_d    = solid_color_i;
      hcnt_d     = '0;
      vcnt_d     = '0;
      ramp_d     = CompWidth'(1);
      bar_cnt_d  = '0;
      bar_idx_d  = '0;
      tvalid_d   = 1'b1;
      testend_d  = 1'b0;
      pixcnt_d   = '0;
      framecnt_d = '0;
    end else if (hs) begin
      pixcnt_d = pixcnt_q + 32'd1;
      hcnt_d   = h_last ? '0 : hcnt_q + CntOne;
      if (h_last) vcnt_d = v_last ? '0 : vcnt_q + CntOne;
      ramp_d   = frame_end ? CompWidth'(1) : ramp_q + CompWidth'(1);
      if (h_last) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (bar_cnt_q == bw_q - CntOne) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 3'(NumBars - 1)) ? bar_idx_q : bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + CntOne;
      end
      if (frame_end) framecnt_d = framecnt_q + 16'd1;
      if (state_d != StRun) begin
        tvalid_d = 1'b0;
        if (state_d == StDone) testend_d = 1'b1;
      end
    end
  end

  // Pattern mux works on next-state values so the first beat is ready right after the start edge.
  always_comb begin
    bar_on  = bar_mask(bar_idx_d);
    pix_d   = '0;
    unique case (mode_d)
      ModeRamp:    pix_d = {3{ramp_d}};
      ModeBars:    pix_d = {{CompWidth{bar_on[2]}}, {CompWidth{bar_on[1]}},
                            {CompWidth{bar_on[0]}}};
      ModeChecker: pix_d = (hcnt_d[ChkLog2] ^ vcnt_d[ChkLog2]) ? '0 : '1;
      ModeSolid:   pix_d = solid_d;
    endcase
    present = load | (hs & (state_d == StRun));
    tdata_d = present ? pix_d : tdata_q;
    tlast_d = present ? (hcnt_d == hsize_d - CntOne) : tlast_q;
    tuser_d = present ? ((hcnt_d == '0) && (vcnt_d == '0)) : tuser_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mode_q     <= ModeRamp;
      hsize_q    <= '0;
      vsize_q    <= '0;
      bw_q       <= '0;
      frames_q   <= '0;
      solid_q    <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      ramp_q     <= '0;
      bar_cnt_q  <= '0;
      bar_idx_q  <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tdata_q    <= '0;
      testend_q  <= 1'b0;
      pixcnt_q   <= '0;
      framecnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hsize_q    <= hsize_d;
      vsize_q    <= vsize_d;
      bw_q       <= bw_d;
      frames_q   <= frames_d;
      solid_q    <= solid_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      ramp_q     <= ramp_d;
      bar_cnt_q  <= bar_cnt_d;
      bar_idx_q  <= bar_idx_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      tdata_q    <= tdata_d;
      testend_q  <= testend_d;
      pixcnt_q   <= pixcnt_d;
      framecnt_q <= framecnt_d;
    end
  end

`ifdef TESTPAT_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, checksum_q, checksum_d;

  always_comb begin
    sum_d      = sum_q;
    checksum_d = checksum_q;
    if (load) begin
      sum_d      = '0;
      checksum_d = '0;
    end else if (hs) begin
      sum_d = frame_end ? '0 : sum_q + 32'(tdata_q);
      if (frame_end) checksum_d = sum_q + 32'(tdata_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q      <= '0;
      checksum_q <= '0;
    end else begin
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
    end
  end

  assign test_checksum_o = checksum_q;
`endif

  assign m_axis.tdata    = tdata_q;
  assign m_axis.tvalid   = tvalid_q;
  assign m_axis.tlast    = tlast_q;
  assign m_axis.tuser    = tuser_q;
  assign testend_o       = testend_q;
  assign test_pixelcnt_o = pixcnt_q;
  assign test_framecnt_o = framecnt_q;

endmodule

// File: tb/tb_testpattern_axis_gen.sv
// Scoreboard bench for testpattern_axis_gen: expected beats queued, monitor pops on handshake.
module tb_testpattern_axis_gen;

  localparam int unsigned Dw = 24;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        teston;
  logic [1:0]  mode;
  logic [11:0] hsz, vsz;
  logic [15:0] frames;
  logic [23:0] solid;
  logic        testend;
  logic [31:0] pixcnt;
  logic [15:0] framecnt;
`ifdef TESTPAT_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  testpattern_axis_gen_if #(.DataWidth(Dw)) axis ();

  testpattern_axis_gen #(
    .DataWidth (Dw),
    .CntWidth  (12),
    .ChkLog2   (1)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .teston_i        (teston),
    .mode_i          (mode),
    .h_size_i        (hsz),
    .v_size_i        (vsz),
    .frames_i        (frames),
    .solid_color_i   (solid),
    .testend_o       (testend),
    .test_pixelcnt_o (pixcnt),
    .test_framecnt_o (framecnt),
`ifdef TESTPAT_CHECKSUM_EN
    .test_checksum_o (checksum),
`endif
    .m_axis          (axis)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        user;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    beats = 0;
  bit    stall_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic l, input logic u);
    beat_t b;
    b.data = d;
    b.last = l;
    b.user = u;
    exp_q.push_back(b);
  endtask

  // Returns just after the posedge on which the target beat was accepted.
  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (beats < target) check("timeout_beats", beats, target);
  endtask

  task automatic configure(input logic [1:0] m, input logic [11:0] h, input logic [11:0] v,
                           input logic [15:0] f, input logic [23:0] s);
    mode   = m;
    hsz    = h;
    vsz    = v;
    frames = f;
    solid  = s;
  endtask

  task automatic push_ramp_4x2();
    for (int i = 0; i < 8; i++) push({3{8'(i + 1)}}, (i % 4) == 3, i == 0);
  endtask

  // TREADY driver: all-ones, or the repeating 1,0,0,1 pattern while stall_en is set.
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis.tready = stall_en ? pat[ph] : 1'b1;
      ph = (ph + 1) % 4;
    end
  end

  // Monitor: handshake at the next posedge is visible at this negedge.
  initial begin
    logic        held;
    logic [23:0] hd;
    logic        hl, hu;
    beat_t       e;
    held = 1'b0;
    hd = '0;
    hl = 1'b0;
    hu = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_ni !== 1'b1) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_tvalid", {31'd0, axis.tvalid}, 32'd1);
          check("stall_tdata", {8'd0, axis.tdata}, {8'd0, hd});
          check("stall_tlast", {31'd0, axis.tlast}, {31'd0, hl});
          check("stall_tuser", {31'd0, axis.tuser}, {31'd0, hu});
        end
        if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {8'd0, axis.tdata}, 32'hdeadbeef);
          end else begin
            e = exp_q.pop_front();
            check("beat_tdata", {8'd0, axis.tdata}, {8'd0, e.data});
            check("beat_tlast", {31'd0, axis.tlast}, {31'd0, e.last});
            check("beat_tuser", {31'd0, axis.tuser}, {31'd0, e.user});
          end
          beats++;
        end
        held = (axis.tvalid === 1'b1) && (axis.tready !== 1'b1);
        hd = axis.tdata;
        hl = axis.tlast;
        hu = axis.tuser;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic [23:0] bar_tab [8];
    logic [15:0] chk_map;
    int base;
    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    chk_map = 16'h33CC; // bit v*4+h set = black
    rst_ni = 1'b0;
    teston = 1'b0;
    configure(2'd0, 12'd0, 12'd0, 16'd0, 24'd0);
    #1;
    check("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    check("rst_tlast", {31'd0, axis.tlast}, 32'd0);
    check("rst_tuser", {31'd0, axis.tuser}, 32'd0);
    check("rst_tdata", {8'd0, axis.tdata}, 32'd0);
    check("rst_testend", {31'd0, testend}, 32'd0);
    check("rst_pixcnt", pixcnt, 32'd0);
    check("rst_framecnt", {16'd0, framecnt}, 32'd0);
    #21 rst_ni = 1'b1;
    repeat (3) @(posedge clk);

    // Ramp 4x2, one frame, no backpressure; also first-beat latency
    #1;
    configure(2'd0, 12'd4, 12'd2, 16'd1, 24'd0);
    base = beats;
    push_ramp_4x2();
    teston = 1'b1;
    @(posedge clk); // E1
    @(posedge clk); // E2
    #1 check("lat_tvalid_e2", {31'd0, axis.tvalid}, 32'd0);
    @(posedge clk); // E3
    #1 check("lat_tvalid_e3", {31'd0, axis.tvalid}, 32'd1);
    check("first_tuser", {31'd0, axis.tuser}, 32'd1);
    wait_beats(base + 8, 40);
    check("ramp_testend", {31'd0, testend}, 32'd1);
    check("ramp_tvalid_off", {31'd0, axis.tvalid}, 32'd0);
    check("ramp_pixcnt", pixcnt, 32'd8);
    check("ramp_framecnt", {16'd0, framecnt}, 32'd1);
`ifdef TESTPAT_CHECKSUM_EN
    check("ramp_checksum", checksum, 32'h242424);
`endif
    teston = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("testend_held_idle", {31'd0, testend}, 32'd1);

    // Same ramp under 1,0,0,1 backpressure
    stall_en = 1'b1;
    base = beats;
    push_ramp_4x2();
    teston = 1'b1;
    wait_beats(base + 8, 80);
    check("stall_testend", {31'd0, testend}, 32'd1);
    check("stall_pixcnt", pixcnt, 32'd8);
    stall_en = 1'b0;
    teston = 1'b0;
    repeat (5) @(posedge clk);

    // Colour bars 16x1: bar width 2
    #1;
    configure(2'd1, 12'd16, 12'd1, 16'd1, 24'd0);
    base = beats;
    for (int i = 0; i < 16; i++) push(bar_tab[i / 2], i == 15, i == 0);
    teston = 1'b1;
    wait_beats(base + 16, 60);
    check("bars_pixcnt", pixcnt, 32'd16);
    teston = 1'b0;
    repeat (5) @(posedge clk);

    // Checkerboard 4x4 with 2-pixel squares
    #1;
    configure(2'd2, 12'd4, 12'd4, 16'd1, 24'd0);
    base = beats;
    for (int i = 0; i < 16; i++) push(chk_map[i] ? 24'h000000 : 24'hFFFFFF, (i % 4) == 3, i == 0);
    teston = 1'b1;
    wait_beats(base + 16, 60);
    check("chk_testend", {31'd0, testend}, 32'd1);
    teston = 1'b0;
    repeat (5) @(posedge clk);

    // Continuous solid 2x2; TESTON drops after beat 5, frame 2 completes
    #1;
    configure(2'd3, 12'd2, 12'd2, 16'd0, 24'h123456);
    base = beats;
    for (int i = 0; i < 8; i++) push(24'h123456, (i % 2) == 1, (i % 4) == 0);
    teston = 1'b1;
    check("cont_testend_start", {31'd0, testend}, 32'd1);
    wait_beats(base + 5, 40);
    teston = 1'b0;
    wait_beats(base + 8, 40);
    check("cont_tvalid_off", {31'd0, axis.tvalid}, 32'd0);
    check("cont_framecnt", {16'd0, framecnt}, 32'd2);
    check("cont_testend", {31'd0, testend}, 32'd0);
    check("cont_pixcnt", pixcnt, 32'd8);
    repeat (6) @(posedge clk);
    #1 check("cont_idle_tvalid", {31'd0, axis.tvalid}, 32'd0);

    // Reset mid-frame, then restart from the first pixel
    configure(2'd0, 12'd4, 12'd2, 16'd1, 24'd0);
    base = beats;
    push_ramp_4x2();
    teston = 1'b1;
    wait_beats(base + 3, 40);
    rst_ni = 1'b0;
    teston = 1'b0;
    #1;
    check("arst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    check("arst_pixcnt", pixcnt, 32'd0);
    check("arst_framecnt", {16'd0, framecnt}, 32'd0);
    check("arst_testend", {31'd0, testend}, 32'd0);
    exp_q.delete();
    #10 rst_ni = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("arst_no_output", {31'd0, axis.tvalid}, 32'd0);
    base = beats;
    push_ramp_4x2();
    teston = 1'b1;
    wait_beats(base + 8, 40);
    check("restart_testend", {31'd0, testend}, 32'd1);
    check("restart_pixcnt", pixcnt, 32'd8);
    check("restart_framecnt", {16'd0, framecnt}, 32'd1);
    teston = 1'b0;
    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
